// File: rtl/border_pkg.sv
// Shared state codes for the nested-border renderer and its sequencer.
package border_pkg;

    localparam int STATE_W = 3;
    localparam int LEVEL_W = 2;

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [LEVEL_W-1:0] level_t;

    localparam state_t ST_EMPTY = 3'd0;
    localparam state_t ST_OUTER = 3'd1;
    localparam state_t ST_MID   = 3'd2;
    localparam state_t ST_FULL  = 3'd3;
    localparam state_t ST_ALT   = 3'd4;

    localparam level_t LEVEL_MIN = 2'd0;
    localparam level_t LEVEL_MAX = 2'd3;

endpackage

// File: rtl/button_debounce.sv
// Synchronises a raw pushbutton, debounces it and emits a press pulse.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 200_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_a;
    logic          sync_b;
    logic          stable;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_a    <= 1'b0;
            sync_b    <= 1'b0;
            stable    <= 1'b0;
            cnt       <= '0;
            btn_pulse <= 1'b0;
        end else begin
            sync_a    <= btn_raw;
            sync_b    <= sync_a;
            btn_pulse <= 1'b0;
            if (sync_b == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                // Accept the change; only presses produce a pulse.
                cnt       <= '0;
                stable    <= sync_b;
                btn_pulse <= sync_b;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/border_state_ctrl.sv
// Button-driven border level sequencer with optional mid-ring blink.
module border_state_ctrl
    import border_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 200_000,
    parameter int BLINK_CYCLES    = 25_000_000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic               btn_blink,
    output logic [STATE_W-1:0] state,
    output logic               blink_en
);

    localparam int BW = $clog2(BLINK_CYCLES);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    logic          up_pulse;
    logic          down_pulse;
    logic          blink_pulse;
    level_t        level;
    level_t        level_n;
    logic          blink_n;
    logic          phase;
    logic          phase_n;
    logic [BW-1:0] bcnt;
    logic [BW-1:0] bcnt_n;
    logic          active;
    logic          active_n;
    state_t        state_n;

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_up),
        .btn_pulse (up_pulse)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_down),
        .btn_pulse (down_pulse)
    );

    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_blink (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (btn_blink),
        .btn_pulse (blink_pulse)
    );

    always_comb begin
        level_n = level;
        if (up_pulse && !down_pulse && level != LEVEL_MAX) begin
            level_n = level + 1'b1;
        end else if (down_pulse && !up_pulse && level != LEVEL_MIN) begin
            level_n = level - 1'b1;
        end
        blink_n  = blink_en ^ blink_pulse;
        active   = (level == LEVEL_MAX) && blink_en;
        active_n = (level_n == LEVEL_MAX) && blink_n;

        // Timer idles at zero outside the blink condition.
        bcnt_n  = '0;
        phase_n = 1'b0;
        if (active) begin
            if (bcnt == BLINK_LAST) begin
                bcnt_n  = '0;
                phase_n = ~phase;
            end else begin
                bcnt_n  = bcnt + 1'b1;
                phase_n = phase;
            end
        end

        // Exiting the condition drops straight to the new level.
        if (active_n && phase_n) begin
            state_n = ST_ALT;
        end else begin
            state_n = {1'b0, level_n};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level    <= LEVEL_MIN;
            blink_en <= 1'b0;
            phase    <= 1'b0;
            bcnt     <= '0;
            state    <= ST_EMPTY;
        end else begin
            level    <= level_n;
            blink_en <= blink_n;
            phase    <= phase_n;
            bcnt     <= bcnt_n;
            state    <= state_n;
        end
    end

endmodule

// File: tb/tb_border_state_ctrl.sv
// Directed bench for border_state_ctrl with short debounce and blink periods.
module tb_border_state_ctrl;

    logic       clk;
    logic       reset;
    logic       btn_up;
    logic       btn_down;
    logic       btn_blink;
    logic [2:0] state;
    logic       blink_en;

    int checks;
    int fails;

    border_state_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .BLINK_CYCLES    (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_blink (btn_blink),
        .state     (state),
        .blink_en  (blink_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_blink = 1'b0;
        reset     = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic press(input logic u, input logic d, input logic b);
        btn_up    = u;
        btn_down  = d;
        btn_blink = b;
        repeat (12) tick();
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_blink = 1'b0;
        repeat (12) tick();
    endtask

    task automatic test_reset;
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_blink = 1'b0;
        reset     = 1'b1;
        tick();
        checks++;
        if (state !== 3'd0) begin
            fails++;
            $display("FAIL reset_state: got %0d want 0", state);
        end
        checks++;
        if (blink_en !== 1'b0) begin
            fails++;
            $display("FAIL reset_blink: got %0b want 0", blink_en);
        end
        reset = 1'b0;
        repeat (5) tick();
        checks++;
        if (state !== 3'd0) begin
            fails++;
            $display("FAIL reset_idle: got %0d want 0", state);
        end
    endtask

    task automatic test_hold;
        logic [2:0] exp;
        do_reset();
        btn_up = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            tick();
            exp = (n >= 7) ? 3'd1 : 3'd0;
            checks++;
            if (state !== exp) begin
                fails++;
                $display("FAIL hold_latency n=%0d: got %0d want %0d",
                         n, state, exp);
            end
        end
        btn_up = 1'b0;
        repeat (12) tick();
        checks++;
        if (state !== 3'd1) begin
            fails++;
            $display("FAIL hold_release: got %0d want 1", state);
        end
    endtask

    task automatic test_up_down;
        logic [2:0] up_exp [5];
        logic [2:0] dn_exp [5];
        up_exp = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd3};
        dn_exp = '{3'd2, 3'd1, 3'd0, 3'd0, 3'd0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            press(1'b1, 1'b0, 1'b0);
            checks++;
            if (state !== up_exp[i]) begin
                fails++;
                $display("FAIL up_press %0d: got %0d want %0d",
                         i, state, up_exp[i]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            press(1'b0, 1'b1, 1'b0);
            checks++;
            if (state !== dn_exp[i]) begin
                fails++;
                $display("FAIL down_press %0d: got %0d want %0d",
                         i, state, dn_exp[i]);
            end
        end
    endtask

    task automatic test_bounce;
        int bad;
        bad = 0;
        do_reset();
        for (int c = 0; c < 20; c++) begin
            btn_up = ((c / 2) % 2) == 0;
            tick();
            if (state !== 3'd0) bad++;
        end
        btn_up = 1'b0;
        repeat (10) tick();
        checks++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bounce_during: got %0d bad cycles want 0", bad);
        end
        checks++;
        if (state !== 3'd0) begin
            fails++;
            $display("FAIL bounce_after: got %0d want 0", state);
        end
    endtask

    task automatic test_blink;
        logic [2:0] exp;
        do_reset();
        repeat (3) press(1'b1, 1'b0, 1'b0);
        checks++;
        if (state !== 3'd3) begin
            fails++;
            $display("FAIL blink_setup: got %0d want 3", state);
        end
        btn_blink = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            tick();
            if (n == 6) begin
                checks++;
                if (blink_en !== 1'b0) begin
                    fails++;
                    $display("FAIL blink_early: got %0b want 0", blink_en);
                end
            end
        end
        checks++;
        if (blink_en !== 1'b1 || state !== 3'd3) begin
            fails++;
            $display("FAIL blink_on: got en=%0b st=%0d want en=1 st=3",
                     blink_en, state);
        end
        for (int j = 1; j <= 45; j++) begin
            tick();
            if (j <= 24) exp = (((j / 8) % 2) == 1) ? 3'd4 : 3'd3;
            else         exp = 3'd2;
            checks++;
            if (state !== exp) begin
                fails++;
                $display("FAIL blink_seq j=%0d: got %0d want %0d",
                         j, state, exp);
            end
            if (j == 10) btn_blink = 1'b0;
            if (j == 18) btn_down  = 1'b1;
            if (j == 30) btn_down  = 1'b0;
        end
        checks++;
        if (blink_en !== 1'b1) begin
            fails++;
            $display("FAIL blink_keep: got %0b want 1", blink_en);
        end
    endtask

    task automatic test_coincide;
        do_reset();
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0);
        checks++;
        if (state !== 3'd2) begin
            fails++;
            $display("FAIL coincide_level: got %0d want 2", state);
        end
        press(1'b1, 1'b1, 1'b1);
        checks++;
        if (state !== 3'd2 || blink_en !== 1'b1) begin
            fails++;
            $display("FAIL coincide_blink: got st=%0d en=%0b want st=2 en=1",
                     state, blink_en);
        end
        press(1'b0, 1'b1, 1'b0);
        checks++;
        if (state !== 3'd1) begin
            fails++;
            $display("FAIL coincide_after: got %0d want 1", state);
        end
    endtask

    task automatic test_async_reset;
        int waited;
        do_reset();
        repeat (3) press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1);
        waited = 0;
        while (state !== 3'd4 && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (state !== 3'd4) begin
            fails++;
            $display("FAIL areset_reach_alt: got %0d want 4", state);
        end
        btn_up = 1'b1;
        repeat (3) tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (state !== 3'd0 || blink_en !== 1'b0) begin
            fails++;
            $display("FAIL areset_clear: got st=%0d en=%0b want st=0 en=0",
                     state, blink_en);
        end
        btn_up = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        repeat (15) tick();
        checks++;
        if (state !== 3'd0 || blink_en !== 1'b0) begin
            fails++;
            $display("FAIL areset_discard: got st=%0d en=%0b want st=0 en=0",
                     state, blink_en);
        end
    endtask

    initial begin
        checks = 0;
        fails  = 0;
        test_reset();
        test_hold();
        test_up_down();
        test_bounce();
        test_blink();
        test_coincide();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule

// File: doc/border_state_ctrl.md
# border_state_ctrl

Sequencer that produces the 3-bit `state` code consumed by the OLED nested-border renderer. It debounces three pushbuttons, steps a border level up or down, and can flash the middle (yellow) ring by alternating the full-border code with the outer-plus-core code. It sits directly upstream of the renderer and drives its `state` input from a single registered output.

## Interface
- `DEBOUNCE_CYCLES`, default 200_000: consecutive stable cycles needed before a button change is accepted. Must be ≥ 2.
- `BLINK_CYCLES`, default 25_000_000: cycles per blink half-period. Must be ≥ 2.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-high reset.
- `btn_up`  in  1  raw pushbutton, asynchronous to `clk`; advances the level.
- `btn_down`  in  1  raw pushbutton, asynchronous; retreats the level.
- `btn_blink`  in  1  raw pushbutton, asynchronous; toggles blink mode.
- `state`  out  3  renderer code: 0 = empty, 1 = outer, 2 = outer+mid, 3 = outer+mid+core, 4 = outer+core.
- `blink_en`  out  1  current blink-mode flag, for an LED indicator.

## Operation
- Each button passes through its own debouncer:
  - 2-FF synchronizer.
  - A counter runs while the synced value differs from the debounced value. It clears whenever they match.
  - The debounced value flips once the counter has seen `DEBOUNCE_CYCLES` consecutive differing cycles.
  - Output is a one-cycle pulse on the debounced rising edge only. Releases produce no pulse.
- Internal `level` is 2 bits, range 0..3:
  - An up pulse increments it, saturating at 3.
  - A down pulse decrements it, saturating at 0.
  - Up and down pulses in the same cycle are both ignored.
- A blink pulse toggles `blink_en`. This is independent of the level pulses, so a blink pulse in the same cycle as an up or down pulse applies both.
- Blink timer:
  - Active only while `level == 3` and `blink_en == 1`.
  - Counts 0..`BLINK_CYCLES`-1, wraps, and toggles `phase` on each wrap.
  - Counter and `phase` are forced to 0 on any cycle where the condition is false. Every blink episode therefore starts on code 3.
- Output selection, registered:
  - `state` = 4 when `level == 3 && blink_en && phase`.
  - Otherwise `state` = `level`.
  - Codes 5–7 are never produced.

## Timing
- Reset values:
  - `state` = 0, `blink_en` = 0.
  - `level`, `phase`, blink counter, all synchronizers, debounced values and debounce counters = 0.
- Reset asserted mid-operation clears everything immediately, even mid-debounce or mid-blink.
- Reset is released synchronously through the codebase's standard reset path.
- Press latency: edge k is the first edge that samples a raw button high, and the button is held. The debounced value goes high at edge k+1+`DEBOUNCE_CYCLES`. The pulse is high during the following cycle. `level`, `blink_en` and `state` update at edge k+2+`DEBOUNCE_CYCLES`.
- Bounce shorter than `DEBOUNCE_CYCLES` cycles restarts the counter and produces no pulse.
- Holding a button generates exactly one pulse. Auto-repeat is not supported.
- Blink rate: while active, `state` is 3 for `BLINK_CYCLES` cycles, then 4 for `BLINK_CYCLES` cycles, and repeats. The first change to 4 occurs `BLINK_CYCLES` cycles after the condition becomes true.
- Leaving the blink condition, by a down pulse or by toggling blink off, takes effect on the same edge as the pulse. `state` goes directly to the new `level` value, never to 4.

## Structure
- Shared package `border_pkg` holds:
  - State code constants `ST_EMPTY`=0, `ST_OUTER`=1, `ST_MID`=2, `ST_FULL`=3, `ST_ALT`=4.
  - The 3-bit state width.
- The renderer imports the same package.
- One sub-module, `button_debounce`, with parameter `DEBOUNCE_CYCLES` and ports `clk`, `reset`, `btn_raw`, `btn_pulse`. It is instantiated three times.
- Counter widths are `$clog2` of their parameters.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES`=4 and `BLINK_CYCLES`=8.
- Reset, then hold `btn_up` high for 20 cycles → `state` goes 0→1 exactly 6 edges after the first sampling edge. No further change while held.
- Four clean up presses, then one extra → `state` sequence 1, 2, 3, 3 (saturates). Five down presses → 2, 1, 0, 0.
- `btn_up` bouncing high/low every 2 cycles for 20 cycles, then low → `state` stays 0, no pulse.
- Level 3, press blink → `blink_en`=1. `state` shows 3 for 8 cycles, then 4 for 8 cycles, alternating. A down press during phase 4 → `state`=2 on the pulse edge, and 4 never recurs.
- Up and down raw inputs driven identically, so both pulses coincide → `level` unchanged.
- Assert `reset` during a blink 4-phase and mid-debounce → `state`=0 and `blink_en`=0 asynchronously. The pending press is discarded.
